// File: rtl/uart_rx_if.sv
// Handshake bundle between uart_rx and its consumer.
//   data_rx    : received word, stable while valid is high
//   valid      : a word is available
//   ready      : consumer accepts the word when valid & ready
//   parity_err : parity mismatch for data_rx, qualified by valid
//   frame_err  : stop bit sampled low for data_rx, qualified by valid
//   overrun    : one-cycle pulse, a completed word was dropped
// master = receiver side, slave = consumer side.
interface uart_rx_if #(
  parameter int BITS_N = 8
);
  logic [BITS_N-1:0] data_rx;
  logic              valid;
  logic              ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  modport master (
    output data_rx, valid, parity_err, frame_err, overrun,
    input  ready
  );

  modport slave (
    input  data_rx, valid, parity_err, frame_err, overrun,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver. Synchronizes the raw line, times each bit from
// the detected start edge, and hands each word to the consumer over a
// valid/ready handshake together with parity and framing status.
//   clk     : system clock
//   rst     : asynchronous, active-low reset
//   uart_in : raw serial line, idle high, asynchronous to clk
//   bus     : uart_rx_if master (data_rx, valid, ready, parity_err,
//             frame_err, overrun)
//
// state     | meaning
// ----------+--------------------------------------------------------------
// IDLE      | line high, waiting for a falling edge on the synchronized line
// START     | timing half a bit to re-check the start bit (glitch filter)
// DATA      | sampling BITS_N data bits mid-bit, LSB first
// PARITY    | sampling the parity bit (only when PARITY_TYPE != 0)
// STOP      | sampling the stop bit; the word is committed on this sample
// WAIT_HIGH | stop bit was low; hold off until the line returns high
module uart_rx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int BITS_N       = 8,
  parameter int PARITY_TYPE  = 0
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     uart_in,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (BITS_N > 1) ? $clog2(BITS_N) : 1;
  localparam logic [CW-1:0] TC_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] TC_BIT  = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] TC_LAST = BW'(BITS_N - 1);
  localparam logic          PAR_ODD = (PARITY_TYPE == 1);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_HIGH
  } state_t;

  state_t            state_q,   state_d;
  logic              sync1_q,   sync1_d;
  logic              sync2_q,   sync2_d;
  logic [CW-1:0]     clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]     bit_cnt_q, bit_cnt_d;
  logic [BITS_N-1:0] shift_q,   shift_d;
  logic              par_bad_q, par_bad_d;
  logic [BITS_N-1:0] data_q,    data_d;
  logic              valid_q,   valid_d;
  logic              perr_q,    perr_d;
  logic              ferr_q,    ferr_d;
  logic              overrun_q, overrun_d;

  logic rxs;
  logic tick_bit;
  logic commit;

  assign rxs      = sync2_q;
  assign tick_bit = (clk_cnt_q == TC_BIT);

  always_comb begin
    state_d   = state_q;
    sync1_d   = uart_in;
    sync2_d   = sync1_q;
    clk_cnt_d = clk_cnt_q + 1'b1;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    overrun_d = 1'b0;
    commit    = 1'b0;

    case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rxs) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == TC_HALF) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          par_bad_d = 1'b0;
          state_d   = rxs ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (tick_bit) begin
          clk_cnt_d = '0;
          shift_d   = {rxs, shift_q[BITS_N-1:1]};
          bit_cnt_d = bit_cnt_q + 1'b1;
          if (bit_cnt_q == TC_LAST) begin
            bit_cnt_d = '0;
            state_d   = (PARITY_TYPE != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (tick_bit) begin
          clk_cnt_d = '0;
          par_bad_d = ((^shift_q) ^ rxs) != PAR_ODD;
          state_d   = S_STOP;
        end
      end
      S_STOP: begin
        if (tick_bit) begin
          clk_cnt_d = '0;
          commit    = 1'b1;
          // Leaving mid-stop-bit lets a start bit that follows immediately
          // be caught without losing a frame.
          state_d   = rxs ? S_IDLE : S_WAIT_HIGH;
        end
      end
      S_WAIT_HIGH: begin
        clk_cnt_d = '0;
        if (rxs) state_d = S_IDLE;
      end
      default: begin
        state_d   = S_IDLE;
        clk_cnt_d = '0;
      end
    endcase

    // An accept in the commit cycle frees the slot, so the new word loads.
    if (commit) begin
      if (!valid_q || bus.ready) begin
        data_d  = shift_q;
        perr_d  = par_bad_d;
        ferr_d  = ~rxs;
        valid_d = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && bus.ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sync1_q   <= 1'b1;
      sync2_q   <= 1'b1;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_bad_q <= 1'b0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      sync1_q   <= sync1_d;
      sync2_q   <= sync2_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_bad_q <= par_bad_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      overrun_q <= overrun_d;
    end
  end

  assign bus.data_rx    = data_q;
  assign bus.valid      = valid_q;
  assign bus.parity_err = perr_q;
  assign bus.frame_err  = ferr_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Testbench for uart_rx: one receiver without parity and one with even
// parity, both at 8 clocks per bit, sharing clock and reset.
module tb_uart_rx;

  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic line_np;
  logic line_ev;

  always #5 clk = ~clk;

  uart_rx_if #(.BITS_N(8)) if_np ();
  uart_rx_if #(.BITS_N(8)) if_ev ();

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(0)) dut_np (
    .clk(clk), .rst(rst_n), .uart_in(line_np), .bus(if_np)
  );

  uart_rx #(.CLKS_PER_BIT(CPB), .BITS_N(8), .PARITY_TYPE(2)) dut_ev (
    .clk(clk), .rst(rst_n), .uart_in(line_ev), .bus(if_ev)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int ovr_np   = 0;

  always @(negedge clk) if (if_np.overrun === 1'b1) ovr_np <= ovr_np + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    bit         sel;       // 0 = no-parity receiver, 1 = even-parity receiver
    logic [7:0] data;
    logic       par;
    logic       stop;
    logic [7:0] exp_data;
    logic       exp_perr;
    logic       exp_ferr;
    int         exp_lat;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic set_line(input bit sel, input logic v);
    if (sel) line_ev = v;
    else     line_np = v;
  endtask

  task automatic drive_bit(input bit sel, input logic v);
    set_line(sel, v);
    ticks(CPB);
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic p, input logic stop);
    drive_bit(sel, 1'b0);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i]);
    if (use_par) drive_bit(sel, p);
    drive_bit(sel, stop);
    set_line(sel, 1'b1);
  endtask

  function automatic logic get_valid(input bit s);
    return s ? if_ev.valid : if_np.valid;
  endfunction
  function automatic logic [7:0] get_data(input bit s);
    return s ? if_ev.data_rx : if_np.data_rx;
  endfunction
  function automatic logic get_perr(input bit s);
    return s ? if_ev.parity_err : if_np.parity_err;
  endfunction
  function automatic logic get_ferr(input bit s);
    return s ? if_ev.frame_err : if_np.frame_err;
  endfunction

  // Counts cycles from the start edge until valid is seen, captures the
  // word, and samples valid once more one cycle later.
  task automatic wait_valid(input bit sel, output int lat, output logic [7:0] d,
                            output logic pe, output logic fe, output logic v_after);
    lat = -1; d = '0; pe = 1'b0; fe = 1'b0; v_after = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      tick();
      if (get_valid(sel) === 1'b1) begin
        lat = k;
        d   = get_data(sel);
        pe  = get_perr(sel);
        fe  = get_ferr(sel);
        tick();
        v_after = get_valid(sel);
        break;
      end
    end
  endtask

  int         lat;
  logic [7:0] rd;
  logic       rpe, rfe, rva;
  int         ovr0;
  int         nv;

  initial begin
    vecs[0] = '{1'b0, 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b0, 1'b0, 79};
    vecs[1] = '{1'b0, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 79};
    vecs[2] = '{1'b0, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b0, 79};
    vecs[3] = '{1'b0, 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 79};
    vecs[4] = '{1'b1, 8'h07, 1'b1, 1'b1, 8'h07, 1'b0, 1'b0, 87};
    vecs[5] = '{1'b1, 8'h07, 1'b0, 1'b1, 8'h07, 1'b1, 1'b0, 87};
    vecs[6] = '{1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 87};
    vecs[7] = '{1'b1, 8'h80, 1'b0, 1'b1, 8'h80, 1'b1, 1'b0, 87};
    vecs[8] = '{1'b1, 8'hFF, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b0, 87};
    vecs[9] = '{1'b1, 8'h5A, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 87};

    rst_n       = 1'b0;
    line_np     = 1'b1;
    line_ev     = 1'b1;
    if_np.ready = 1'b1;
    if_ev.ready = 1'b1;
    ticks(3);
    check("reset valid_np",   {31'd0, if_np.valid},      32'd0);
    check("reset data_np",    {24'd0, if_np.data_rx},    32'd0);
    check("reset perr_np",    {31'd0, if_np.parity_err}, 32'd0);
    check("reset ferr_np",    {31'd0, if_np.frame_err},  32'd0);
    check("reset overrun_np", {31'd0, if_np.overrun},    32'd0);
    check("reset valid_ev",   {31'd0, if_ev.valid},      32'd0);
    rst_n = 1'b1;
    ticks(5);

    // Single frames, ready held high.
    for (int v = 0; v < 10; v++) begin
      fork
        send_frame(vecs[v].sel, vecs[v].data, vecs[v].sel, vecs[v].par, vecs[v].stop);
        wait_valid(vecs[v].sel, lat, rd, rpe, rfe, rva);
      join
      check($sformatf("vec%0d latency", v), lat, vecs[v].exp_lat);
      check($sformatf("vec%0d data", v), {24'd0, rd}, {24'd0, vecs[v].exp_data});
      check($sformatf("vec%0d parity_err", v), {31'd0, rpe}, {31'd0, vecs[v].exp_perr});
      check($sformatf("vec%0d frame_err", v), {31'd0, rfe}, {31'd0, vecs[v].exp_ferr});
      check($sformatf("vec%0d valid_one_cycle", v), {31'd0, rva}, 32'd0);
      ticks(12);
    end

    // Overrun: ready low across two words.
    if_np.ready = 1'b0;
    ovr0 = ovr_np;
    fork
      send_frame(1'b0, 8'h11, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, lat, rd, rpe, rfe, rva);
    join
    check("ovr first data", {24'd0, rd}, 32'h11);
    check("ovr first held", {31'd0, rva}, 32'd1);
    ticks(12);
    send_frame(1'b0, 8'h22, 1'b0, 1'b0, 1'b1);
    ticks(4);
    check("ovr data kept",  {24'd0, if_np.data_rx}, 32'h11);
    check("ovr valid kept", {31'd0, if_np.valid}, 32'd1);
    check("ovr pulse count", ovr_np - ovr0, 32'd1);
    if_np.ready = 1'b1;
    tick();
    check("ovr valid drop", {31'd0, if_np.valid}, 32'd0);
    ticks(8);

    // Accept in the same cycle as the next commit.
    if_np.ready = 1'b0;
    fork
      send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, lat, rd, rpe, rfe, rva);
    join
    check("acc first data", {24'd0, rd}, 32'h33);
    ticks(12);
    ovr0 = ovr_np;
    fork
      send_frame(1'b0, 8'h44, 1'b0, 1'b0, 1'b1);
      begin
        ticks(78);
        if_np.ready = 1'b1;
        check("acc pre-commit data", {24'd0, if_np.data_rx}, 32'h33);
        tick();
        if_np.ready = 1'b0;
        check("acc new data",  {24'd0, if_np.data_rx}, 32'h44);
        check("acc valid stays", {31'd0, if_np.valid}, 32'd1);
      end
    join
    ticks(2);
    check("acc no overrun", ovr_np - ovr0, 32'd0);
    if_np.ready = 1'b1;
    tick();
    check("acc valid drop", {31'd0, if_np.valid}, 32'd0);
    ticks(8);

    // Short glitch on an idle line.
    line_np = 1'b0;
    ticks(2);
    line_np = 1'b1;
    nv = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (if_np.valid === 1'b1) nv++;
    end
    check("glitch no valid", nv, 32'd0);

    // Line held low for 20 bit times: exactly one framing-error word.
    nv = 0;
    rd = 8'hEE; rpe = 1'b1; rfe = 1'b0;
    fork
      begin
        line_np = 1'b0;
        ticks(20 * CPB);
        line_np = 1'b1;
      end
      for (int k = 0; k < 220; k++) begin
        tick();
        if (if_np.valid === 1'b1) begin
          nv++;
          if (nv == 1) begin
            rd  = if_np.data_rx;
            rpe = if_np.parity_err;
            rfe = if_np.frame_err;
          end
        end
      end
    join
    check("break word count", nv, 32'd1);
    check("break data", {24'd0, rd}, 32'h00);
    check("break frame_err", {31'd0, rfe}, 32'd1);
    check("break parity_err", {31'd0, rpe}, 32'd0);
    ticks(4);
    fork
      send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, lat, rd, rpe, rfe, rva);
    join
    check("post-break data", {24'd0, rd}, 32'h5A);
    check("post-break frame_err", {31'd0, rfe}, 32'd0);
    check("post-break latency", lat, 32'd79);
    ticks(12);

    // Reset during bit 3 with a word pending.
    if_np.ready = 1'b0;
    fork
      send_frame(1'b0, 8'h96, 1'b0, 1'b0, 1'b0);
      wait_valid(1'b0, lat, rd, rpe, rfe, rva);
    join
    check("pre-reset held valid", {31'd0, rva}, 32'd1);
    check("pre-reset frame_err", {31'd0, rfe}, 32'd1);
    ticks(12);
    fork
      send_frame(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);
      begin
        ticks(36);
        rst_n = 1'b0;
        #1;
        check("midrst valid",     {31'd0, if_np.valid},      32'd0);
        check("midrst data",      {24'd0, if_np.data_rx},    32'd0);
        check("midrst frame_err", {31'd0, if_np.frame_err},  32'd0);
        check("midrst perr",      {31'd0, if_np.parity_err}, 32'd0);
        check("midrst overrun",   {31'd0, if_np.overrun},    32'd0);
      end
    join
    ticks(2);
    check("held rst valid", {31'd0, if_np.valid}, 32'd0);
    rst_n = 1'b1;
    if_np.ready = 1'b1;
    ticks(4);
    fork
      send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
      wait_valid(1'b0, lat, rd, rpe, rfe, rva);
    join
    check("after rst data", {24'd0, rd}, 32'h3C);
    check("after rst perr", {31'd0, rpe}, 32'd0);
    check("after rst ferr", {31'd0, rfe}, 32'd0);
    check("after rst latency", lat, 32'd79);
    ticks(10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
